jt12_cen_gen: RTL and testbench

JT12_CEN_GEN -- requirements
Module: jt12_cen_gen

---
 rtl/jt12_cen_gen.sv | 140 ++++++++++++++
 tb/tb_jt12_cen_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/jt12_cen_gen.sv
// ============================================================================
// Module      : jt12_cen_gen
// Description : OPN/SSG/ADPCM clock-enable generator with glitch-free divider
//               switching and sync realignment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jt12_cen_gen #(
    parameter int USE_SSG     = 0,
    parameter int NUM_CH      = 6,
    parameter int ADPCM_DIV   = 4,
    parameter int ADPCM3_DIV  = 6,
    parameter int ADPCM55_DIV = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       sync,
    input  logic [1:0] div_setting,
    output logic       clk_en,
    output logic       clk_en_ssg,
    output logic       clk_en_adpcm,
    output logic       clk_en_adpcm3,
    output logic       clk_en_55,
    output logic       div_busy
);

    localparam logic [4:0] C_ADPCM_LAST  = 5'(ADPCM_DIV - 1);
    localparam logic [2:0] C_ADPCM3_LAST = 3'(ADPCM3_DIV - 1);
    localparam logic [2:0] C_55_LAST     = 3'(ADPCM55_DIV - 1);
    localparam logic       C_SSG_EN      = (USE_SSG != 0);

    logic [2:0] r_opn_cnt;
    logic [1:0] r_ssg_cnt;
    logic [4:0] r_adpcm_cnt;
    logic [2:0] r_adpcm3_cnt;
    logic [2:0] r_cnt55;

    logic [2:0] r_opn_div;
    logic [2:0] r_ssg_div;
    logic [2:0] r_pend_opn;
    logic [2:0] r_pend_ssg;
    logic       r_busy;

    logic [2:0] w_req_opn;
    logic [2:0] w_req_ssg;
    logic       w_req_diff;
    logic       w_opn_last;
    logic       w_ssg_last;
    logic       w_apply;
    logic       w_adv;

    always_comb begin
        w_req_opn = 3'd6;
        w_req_ssg = 3'd4;
        if (NUM_CH != 6) begin
            if (!div_setting[1]) begin
                w_req_opn = 3'd2;
                w_req_ssg = 3'd1;
            end else if (div_setting[0]) begin
                w_req_opn = 3'd3;
                w_req_ssg = 3'd2;
            end
        end
    end

    assign w_req_diff = (w_req_opn != r_opn_div) || (w_req_ssg != r_ssg_div);
    assign w_opn_last = (r_opn_cnt == r_opn_div - 3'd1);
    assign w_ssg_last = (r_ssg_cnt == 2'(r_ssg_div - 3'd1));
    assign w_adv      = cen & ~sync;
    // A new divider only takes over at the natural end of an OPN period.
    assign w_apply    = w_adv & r_busy & w_opn_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_opn_cnt     <= '0;
            r_ssg_cnt     <= '0;
            r_adpcm_cnt   <= '0;
            r_adpcm3_cnt  <= '0;
            r_cnt55       <= '0;
            r_opn_div     <= w_req_opn;
            r_ssg_div     <= w_req_ssg;
            r_pend_opn    <= w_req_opn;
            r_pend_ssg    <= w_req_ssg;
            r_busy        <= 1'b0;
            clk_en        <= 1'b0;
            clk_en_ssg    <= 1'b0;
            clk_en_adpcm  <= 1'b0;
            clk_en_adpcm3 <= 1'b0;
            clk_en_55     <= 1'b0;
        end else begin
            clk_en        <= w_adv & (r_opn_cnt == 3'd0);
            clk_en_ssg    <= C_SSG_EN & w_adv & (r_ssg_cnt == 2'd0);
            clk_en_adpcm  <= w_adv & (r_adpcm_cnt == 5'd0);
            clk_en_adpcm3 <= w_adv & (r_adpcm_cnt == 5'd0) & (r_adpcm3_cnt == 3'd0);
            clk_en_55     <= w_adv & (r_adpcm_cnt == 5'd0) & (r_adpcm3_cnt == 3'd0)
                             & (r_cnt55 == 3'd0);

            if (w_apply) begin
                r_opn_div <= r_pend_opn;
                r_ssg_div <= r_pend_ssg;
                r_busy    <= 1'b0;
            end else if (w_req_diff) begin
                r_pend_opn <= w_req_opn;
                r_pend_ssg <= w_req_ssg;
                r_busy     <= 1'b1;
            end else begin
                r_busy <= 1'b0;
            end

            if (sync) begin
                r_opn_cnt    <= '0;
                r_ssg_cnt    <= '0;
                r_adpcm_cnt  <= '0;
                r_adpcm3_cnt <= '0;
                r_cnt55      <= '0;
            end else if (cen) begin
                if (w_apply) begin
                    r_opn_cnt <= '0;
                    r_ssg_cnt <= '0;
                end else begin
                    r_opn_cnt <= w_opn_last ? 3'd0 : r_opn_cnt + 3'd1;
                    r_ssg_cnt <= w_ssg_last ? 2'd0 : r_ssg_cnt + 2'd1;
                end
                r_adpcm_cnt <= (r_adpcm_cnt == C_ADPCM_LAST) ? 5'd0 : r_adpcm_cnt + 5'd1;
                if (r_adpcm_cnt == 5'd0) begin
                    r_adpcm3_cnt <= (r_adpcm3_cnt == C_ADPCM3_LAST) ? 3'd0 : r_adpcm3_cnt + 3'd1;
                    if (r_adpcm3_cnt == 3'd0)
                        r_cnt55 <= (r_cnt55 == C_55_LAST) ? 3'd0 : r_cnt55 + 3'd1;
                end
            end
        end
    end

    assign div_busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_jt12_cen_gen.sv
// ============================================================================
// Module      : tb_jt12_cen_gen
// Description : Self-checking bench for jt12_cen_gen against a cen-count model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jt12_cen_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic       sync = 1'b0;
    logic [1:0] div_setting = 2'b10;
    logic       clk_en, clk_en_ssg, clk_en_adpcm, clk_en_adpcm3, clk_en_55, div_busy;

    int vectors = 0;
    int miscompares = 0;

    // Model: cen counts since the last restart, divided with plain modulo.
    int m_k, m_ka, m_opn, m_ssg, m_popn, m_pssg;
    bit m_busy;
    logic [5:0] exp_vec;
    logic [5:0] obs;

    jt12_cen_gen #(
        .USE_SSG    (1),
        .NUM_CH     (3),
        .ADPCM_DIV  (4),
        .ADPCM3_DIV (6),
        .ADPCM55_DIV(6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cen          (cen),
        .sync         (sync),
        .div_setting  (div_setting),
        .clk_en       (clk_en),
        .clk_en_ssg   (clk_en_ssg),
        .clk_en_adpcm (clk_en_adpcm),
        .clk_en_adpcm3(clk_en_adpcm3),
        .clk_en_55    (clk_en_55),
        .div_busy     (div_busy)
    );

    always #5 clk = ~clk;

    function automatic void dec(input logic [1:0] ds, output int o, output int s);
        if (!ds[1]) begin o = 2; s = 1; end
        else if (ds[0]) begin o = 3; s = 2; end
        else begin o = 6; s = 4; end
    endfunction

    task automatic step(input logic r, input logic c, input logic s, input logic [1:0] ds);
        int ro, rs;
        bit en, ap;
        @(negedge clk);
        rst = r; cen = c; sync = s; div_setting = ds;
        dec(ds, ro, rs);
        if (r) begin
            exp_vec = '0;
            m_k = 0; m_ka = 0;
            m_opn = ro; m_ssg = rs; m_popn = ro; m_pssg = rs;
            m_busy = 0;
        end else begin
            en = c && !s;
            ap = en && m_busy && ((m_k % m_opn) == m_opn - 1);
            exp_vec[5] = en && ((m_k % m_opn) == 0);
            exp_vec[4] = en && ((m_k % m_ssg) == 0);
            exp_vec[3] = en && ((m_ka % 4) == 0);
            exp_vec[2] = en && ((m_ka % 24) == 0);
            exp_vec[1] = en && ((m_ka % 144) == 0);
            if (ap) begin
                m_opn = m_popn; m_ssg = m_pssg; m_busy = 0;
            end else if (ro != m_opn || rs != m_ssg) begin
                m_popn = ro; m_pssg = rs; m_busy = 1;
            end else begin
                m_busy = 0;
            end
            if (s) begin
                m_k = 0; m_ka = 0;
            end else if (c) begin
                m_k  = ap ? 0 : m_k + 1;
                m_ka = (m_ka + 1) % 144;
            end
            exp_vec[0] = m_busy;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'($urandom % 2), 1'($urandom % 2), 2'b11);
            obs = {clk_en, clk_en_ssg, clk_en_adpcm, clk_en_adpcm3, clk_en_55, div_busy};
            vectors++;
            if (obs !== exp_vec) begin
                miscompares++;
                $display("FAIL reset t=%0t got=%b exp=%b", $time, obs, exp_vec);
            end
        end
    endtask

    task automatic test_fixed_rate();
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b1, 1'b0, 2'b11);
            obs = {clk_en, clk_en_ssg, clk_en_adpcm, clk_en_adpcm3, clk_en_55, div_busy};
            vectors++;
            if (obs !== exp_vec) begin
                miscompares++;
                $display("FAIL fixed_rate t=%0t got=%b exp=%b", $time, obs, exp_vec);
            end
        end
    endtask

    task automatic test_adpcm_chain();
        for (int i = 0; i < 310; i++) begin
            step(i == 0, 1'b1, 1'b0, 2'b10);
            obs = {clk_en, clk_en_ssg, clk_en_adpcm, clk_en_adpcm3, clk_en_55, div_busy};
            vectors++;
            if (obs !== exp_vec) begin
                miscompares++;
                $display("FAIL adpcm_chain t=%0t got=%b exp=%b", $time, obs, exp_vec);
            end
        end
    endtask

    task automatic test_div_change();
        logic [1:0] ds;
        for (int i = 0; i < 80; i++) begin
            if (i < 9)       ds = 2'b10;
            else if (i < 30) ds = 2'b00;
            else if (i < 52) ds = 2'b10;
            else if (i < 54) ds = 2'b11;
            else if (i < 70) ds = 2'b10;
            else             ds = 2'b01;
            step(i == 0, 1'b1, 1'b0, ds);
            obs = {clk_en, clk_en_ssg, clk_en_adpcm, clk_en_adpcm3, clk_en_55, div_busy};
            vectors++;
            if (obs !== exp_vec) begin
                miscompares++;
                $display("FAIL div_change t=%0t got=%b exp=%b", $time, obs, exp_vec);
            end
        end
    endtask

    task automatic test_sync();
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 1'(i % 2), (i == 13 || i == 27 || i == 40), 2'b10);
            obs = {clk_en, clk_en_ssg, clk_en_adpcm, clk_en_adpcm3, clk_en_55, div_busy};
            vectors++;
            if (obs !== exp_vec) begin
                miscompares++;
                $display("FAIL sync t=%0t got=%b exp=%b", $time, obs, exp_vec);
            end
        end
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 24; i++) begin
            step(i == 11, 1'b1, 1'b0, 2'b11);
            obs = {clk_en, clk_en_ssg, clk_en_adpcm, clk_en_adpcm3, clk_en_55, div_busy};
            vectors++;
            if (obs !== exp_vec) begin
                miscompares++;
                $display("FAIL rst_mid t=%0t got=%b exp=%b", $time, obs, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] ds = 2'b10;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 40 == 0) ds = 2'($urandom_range(0, 3));
            step(($urandom % 200) == 0, ($urandom % 3) != 0, ($urandom % 50) == 0, ds);
            obs = {clk_en, clk_en_ssg, clk_en_adpcm, clk_en_adpcm3, clk_en_55, div_busy};
            vectors++;
            if (obs !== exp_vec) begin
                miscompares++;
                $display("FAIL random t=%0t got=%b exp=%b", $time, obs, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed_rate();
        test_adpcm_chain();
        test_div_change();
        test_sync();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
